reram_xbar_arbiter: RTL and testbench

//   Shares one ReRAM crossbar compute port between NUM_REQ requesters (layer controllers, test DMA).

---
 rtl/reram_xbar_arbiter.sv | 159 +++++++++++++++
 tb/tb_reram_xbar_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reram_xbar_arbiter.sv
// reram_xbar_arbiter: round-robin arbiter that shares one ReRAM crossbar
// compute port between NUM_REQ requesters. Only one crossbar op is in
// flight at a time. Each op issues a one-cycle compute pulse and then waits
// for the crossbar result or a timeout. The result goes back to the
// requester that was granted.
module reram_xbar_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int GNT_W   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*IDX_W-1:0]   req_idx_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic signed [DATA_W-1:0]   rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       xbar_compute_o,
  output logic [IDX_W-1:0]           xbar_input_idx_o,
  input  logic signed [DATA_W-1:0]   xbar_result_i,
  input  logic                       xbar_valid_i,
  output logic                       busy_o,
  output logic [GNT_W-1:0]           grant_id_o
);

  // The WAIT counter only ever reaches TIMEOUT-1 before the op leaves WAIT.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                     state_q;
  logic [GNT_W-1:0]           ptr_q;
  logic [GNT_W-1:0]           grant_id_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [NUM_REQ-1:0]         req_ready_q;
  logic [NUM_REQ-1:0]         rsp_valid_q;
  logic signed [DATA_W-1:0]   rsp_data_q;
  logic                       rsp_err_q;
  logic                       xbar_compute_q;
  logic [IDX_W-1:0]           xbar_input_idx_q;
  logic                       busy_q;

  logic [GNT_W-1:0]           sel_d;
  logic                       any_req;
  logic [GNT_W:0]             cand_sum;
  logic [GNT_W-1:0]           cand;
  logic [IDX_W-1:0]           req_idx_arr [NUM_REQ];

  // Split the packed index bus into one entry per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_idx_arr[i] = req_idx_i[i*IDX_W +: IDX_W];
  end

  assign any_req = |req_valid_i;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GNT_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin search from pointer+1 with wraparound. The first requester
  // found is the winner.
  always_comb begin
    sel_d    = ptr_q;
    cand_sum = '0;
    cand     = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand_sum = {1'b0, ptr_q} + (GNT_W+1)'(off);
      if (cand_sum >= (GNT_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (GNT_W+1)'(NUM_REQ);
      end
      cand = cand_sum[GNT_W-1:0];
      if (req_valid_i[cand]) begin
        sel_d = cand;
      end
    end
  end

  // Single FSM that drives every output from a register.
  // Pulse outputs default low and are raised for exactly one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_IDLE;
      ptr_q            <= GNT_W'(NUM_REQ-1);
      grant_id_q       <= '0;
      cnt_q            <= '0;
      req_ready_q      <= '0;
      rsp_valid_q      <= '0;
      rsp_data_q       <= '0;
      rsp_err_q        <= 1'b0;
      xbar_compute_q   <= 1'b0;
      xbar_input_idx_q <= '0;
      busy_q           <= 1'b0;
    end else begin
      req_ready_q    <= '0;
      rsp_valid_q    <= '0;
      xbar_compute_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            ptr_q            <= sel_d;
            grant_id_q       <= sel_d;
            req_ready_q      <= onehot(sel_d);
            xbar_compute_q   <= 1'b1;
            xbar_input_idx_q <= req_idx_arr[sel_d];
            busy_q           <= 1'b1;
            state_q          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (xbar_valid_i) begin
            rsp_data_q  <= xbar_result_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= onehot(grant_id_q);
            state_q     <= ST_RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= onehot(grant_id_q);
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o      = req_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_err_o        = rsp_err_q;
  assign xbar_compute_o   = xbar_compute_q;
  assign xbar_input_idx_o = xbar_input_idx_q;
  assign busy_o           = busy_q;
  assign grant_id_o       = grant_id_q;

endmodule

// File: tb/tb_reram_xbar_arbiter.sv
// tb_reram_xbar_arbiter: directed bench for the crossbar arbiter. It runs
// with a short timeout. Inputs are driven and outputs are sampled on the
// falling edge.
module tb_reram_xbar_arbiter;

  localparam int NR = 4;
  localparam int IW = 16;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int GW = 2;

  logic           clk;
  logic           rstN;
  logic [NR-1:0]  reqValid;
  logic [NR*IW-1:0] reqIdx;
  logic [NR-1:0]  reqReady;
  logic [NR-1:0]  rspValid;
  logic [DW-1:0]  rspData;
  logic           rspErr;
  logic           xbarCompute;
  logic [IW-1:0]  xbarInputIdx;
  logic [DW-1:0]  xbarResult;
  logic           xbarValid;
  logic           busy;
  logic [GW-1:0]  grantId;

  int checks = 0;
  int errors = 0;

  reram_xbar_arbiter #(
    .NUM_REQ (NR),
    .IDX_W   (IW),
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .GNT_W   (GW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rstN),
    .req_valid_i      (reqValid),
    .req_idx_i        (reqIdx),
    .req_ready_o      (reqReady),
    .rsp_valid_o      (rspValid),
    .rsp_data_o       (rspData),
    .rsp_err_o        (rspErr),
    .xbar_compute_o   (xbarCompute),
    .xbar_input_idx_o (xbarInputIdx),
    .xbar_result_i    (xbarResult),
    .xbar_valid_i     (xbarValid),
    .busy_o           (busy),
    .grant_id_o       (grantId)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] rv, input logic [NR*IW-1:0] idx,
                               input logic xv, input logic [DW-1:0] res);
    reqValid   = rv;
    reqIdx     = idx;
    xbarValid  = xv;
    xbarResult = res;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " reqReady"}, 64'(reqReady), 64'h0);
    checkOutput({tag, " rspValid"}, 64'(rspValid), 64'h0);
    checkOutput({tag, " rspData"}, 64'(rspData), 64'h0);
    checkOutput({tag, " rspErr"}, 64'(rspErr), 64'h0);
    checkOutput({tag, " compute"}, 64'(xbarCompute), 64'h0);
    checkOutput({tag, " inputIdx"}, 64'(xbarInputIdx), 64'h0);
    checkOutput({tag, " busy"}, 64'(busy), 64'h0);
    checkOutput({tag, " grantId"}, 64'(grantId), 64'h0);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // Linear directed sequence covering reset, single op, RR fairness, timeout,
  // stray strobes and reset mid-op.
  initial begin
    logic [NR*IW-1:0] idxAll;
    logic [NR-1:0]    expOh;

    applyStimulus('0, '0, 1'b0, '0);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rstN = 1'b1;

    // Test 1: single request from requester 1.
    @(negedge clk);
    checkOutput("t1 idle busy", 64'(busy), 64'h0);
    applyStimulus(4'b0010, 64'h0000_0000_0005_0000, 1'b0, '0);
    @(negedge clk);
    checkOutput("t1 reqReady", 64'(reqReady), 64'h2);
    checkOutput("t1 compute", 64'(xbarCompute), 64'h1);
    checkOutput("t1 inputIdx", 64'(xbarInputIdx), 64'h5);
    checkOutput("t1 grantId", 64'(grantId), 64'h1);
    checkOutput("t1 busy", 64'(busy), 64'h1);
    applyStimulus('0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("t1 compute drop", 64'(xbarCompute), 64'h0);
    checkOutput("t1 reqReady drop", 64'(reqReady), 64'h0);
    checkOutput("t1 wait rspValid", 64'(rspValid), 64'h0);
    @(negedge clk);
    checkOutput("t1 idx held", 64'(xbarInputIdx), 64'h5);
    @(negedge clk);
    checkOutput("t1 wait2 rspValid", 64'(rspValid), 64'h0);
    applyStimulus('0, '0, 1'b1, 16'h7FF0);
    @(negedge clk);
    checkOutput("t1 rspValid", 64'(rspValid), 64'h2);
    checkOutput("t1 rspData", 64'(rspData), 64'h7FF0);
    checkOutput("t1 rspErr", 64'(rspErr), 64'h0);
    applyStimulus('0, '0, 1'b0, 16'h1234);
    @(negedge clk);
    checkOutput("t1 rspValid clear", 64'(rspValid), 64'h0);
    checkOutput("t1 busy clear", 64'(busy), 64'h0);
    checkOutput("t1 rspData hold", 64'(rspData), 64'h7FF0);

    // Test 2: all four requesting, one op per four cycles in RR order.
    doReset();
    idxAll = 64'h0103_0102_0101_0100;
    applyStimulus(4'b1111, idxAll, 1'b0, '0);
    for (int op = 0; op < 5; op++) begin
      expOh = 4'b0001 << (op % 4);
      @(negedge clk);
      checkOutput("t2 reqReady", 64'(reqReady), 64'(expOh));
      checkOutput("t2 compute", 64'(xbarCompute), 64'h1);
      checkOutput("t2 grantId", 64'(grantId), 64'(op % 4));
      checkOutput("t2 inputIdx", 64'(xbarInputIdx), 64'(16'h0100 + 16'(op % 4)));
      @(negedge clk);
      checkOutput("t2 wait rspValid", 64'(rspValid), 64'h0);
      applyStimulus(4'b1111, idxAll, 1'b1, 16'h0A00 + 16'(op % 4));
      @(negedge clk);
      checkOutput("t2 rspValid", 64'(rspValid), 64'(expOh));
      checkOutput("t2 rspData", 64'(rspData), 64'(16'h0A00 + 16'(op % 4)));
      applyStimulus(4'b1111, idxAll, 1'b0, '0);
      @(negedge clk);
      checkOutput("t2 idle busy", 64'(busy), 64'h0);
      checkOutput("t2 idle reqReady", 64'(reqReady), 64'h0);
    end
    applyStimulus('0, '0, 1'b0, '0);

    // Test 3: timeout after exactly TO wait cycles, then a normal op.
    applyStimulus(4'b1000, 64'h0303_0000_0000_0000, 1'b0, '0);
    @(negedge clk);
    checkOutput("t3 reqReady", 64'(reqReady), 64'h8);
    checkOutput("t3 grantId", 64'(grantId), 64'h3);
    applyStimulus('0, '0, 1'b0, '0);
    for (int w = 0; w < TO; w++) begin
      @(negedge clk);
      checkOutput("t3 wait rspValid", 64'(rspValid), 64'h0);
    end
    @(negedge clk);
    checkOutput("t3 rspValid", 64'(rspValid), 64'h8);
    checkOutput("t3 rspErr", 64'(rspErr), 64'h1);
    checkOutput("t3 rspData", 64'(rspData), 64'h0);
    applyStimulus(4'b0001, 64'h0000_0000_0000_0042, 1'b0, '0);
    @(negedge clk);
    checkOutput("t3 idle busy", 64'(busy), 64'h0);
    checkOutput("t3 err hold", 64'(rspErr), 64'h1);
    @(negedge clk);
    checkOutput("t3b reqReady", 64'(reqReady), 64'h1);
    checkOutput("t3b grantId", 64'(grantId), 64'h0);
    applyStimulus('0, '0, 1'b0, '0);
    @(negedge clk);
    applyStimulus('0, '0, 1'b1, 16'h0042);
    @(negedge clk);
    checkOutput("t3b rspValid", 64'(rspValid), 64'h1);
    checkOutput("t3b rspErr", 64'(rspErr), 64'h0);
    checkOutput("t3b rspData", 64'(rspData), 64'h0042);
    applyStimulus('0, '0, 1'b0, '0);

    // Test 4: stray strobes in IDLE, ISSUE and RESP are ignored.
    @(negedge clk);
    applyStimulus('0, '0, 1'b1, 16'h1111);
    @(negedge clk);
    checkOutput("t4 stray idle busy", 64'(busy), 64'h0);
    checkOutput("t4 stray idle rspValid", 64'(rspValid), 64'h0);
    checkOutput("t4 stray idle rspData", 64'(rspData), 64'h0042);
    applyStimulus(4'b0100, 64'h0000_0204_0000_0000, 1'b0, '0);
    @(negedge clk);
    checkOutput("t4 reqReady", 64'(reqReady), 64'h4);
    checkOutput("t4 grantId", 64'(grantId), 64'h2);
    applyStimulus('0, '0, 1'b1, 16'h2222);
    @(negedge clk);
    checkOutput("t4 stray issue rspValid", 64'(rspValid), 64'h0);
    applyStimulus('0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("t4 wait rspValid", 64'(rspValid), 64'h0);
    applyStimulus('0, '0, 1'b1, 16'hFF38);
    @(negedge clk);
    checkOutput("t4 rspValid", 64'(rspValid), 64'h4);
    checkOutput("t4 rspData", 64'(rspData), 64'hFF38);
    checkOutput("t4 rspErr", 64'(rspErr), 64'h0);
    applyStimulus('0, '0, 1'b1, 16'h3333);
    @(negedge clk);
    checkOutput("t4 stray resp rspValid", 64'(rspValid), 64'h0);
    checkOutput("t4 stray resp rspData", 64'(rspData), 64'hFF38);
    applyStimulus(4'b0010, 64'h0000_0000_0201_0000, 1'b0, '0);
    @(negedge clk);
    checkOutput("t4b reqReady", 64'(reqReady), 64'h2);
    checkOutput("t4b grantId", 64'(grantId), 64'h1);
    applyStimulus('0, '0, 1'b0, '0);
    for (int w = 0; w < TO; w++) begin
      @(negedge clk);
      checkOutput("t4b wait rspValid", 64'(rspValid), 64'h0);
      if (w == TO-1) applyStimulus('0, '0, 1'b1, 16'h0077);
    end
    @(negedge clk);
    checkOutput("t4b rspValid", 64'(rspValid), 64'h2);
    checkOutput("t4b rspErr", 64'(rspErr), 64'h0);
    checkOutput("t4b rspData", 64'(rspData), 64'h0077);
    applyStimulus('0, '0, 1'b0, '0);

    // Test 5: reset during WAIT drops the op; requester 0 wins after release.
    @(negedge clk);
    applyStimulus(4'b0100, 64'h0000_0505_0000_0000, 1'b0, '0);
    @(negedge clk);
    checkOutput("t5 reqReady", 64'(reqReady), 64'h4);
    applyStimulus('0, '0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkResetState("t5 reset");
    idxAll = 64'h0000_0502_0000_0500;
    @(negedge clk);
    applyStimulus(4'b0101, idxAll, 1'b1, 16'h5555);
    @(negedge clk);
    checkOutput("t5 in reset rspValid", 64'(rspValid), 64'h0);
    rstN = 1'b1;
    checkOutput("t5 release busy", 64'(busy), 64'h0);
    @(negedge clk);
    checkOutput("t5 reqReady", 64'(reqReady), 64'h1);
    checkOutput("t5 grantId", 64'(grantId), 64'h0);
    checkOutput("t5 inputIdx", 64'(xbarInputIdx), 64'h0500);
    checkOutput("t5 late rspValid", 64'(rspValid), 64'h0);
    applyStimulus(4'b0100, idxAll, 1'b0, '0);
    @(negedge clk);
    checkOutput("t5 wait rspValid", 64'(rspValid), 64'h0);
    applyStimulus(4'b0100, idxAll, 1'b1, 16'h0050);
    @(negedge clk);
    checkOutput("t5 rspValid", 64'(rspValid), 64'h1);
    checkOutput("t5 rspData", 64'(rspData), 64'h0050);
    applyStimulus(4'b0100, idxAll, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5b reqReady", 64'(reqReady), 64'h4);
    checkOutput("t5b grantId", 64'(grantId), 64'h2);
    applyStimulus('0, '0, 1'b0, '0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
